// File: rtl/state_seq_arbiter.sv
// Owns the FSM state register and runs its update loop: publish state, wait out the
// backward latency, accept one round-robin arbitrated next state, wait out the forward latency.
module state_seq_arbiter #(
  parameter int                  NUM_REQ     = 4,
  parameter int                  STATE_W     = 3,
  parameter int                  BL_CYC      = 8,
  parameter int                  FL_CYC      = 2,
  parameter logic [STATE_W-1:0]  RESET_STATE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         st_valid,
  input  logic                         st_ready,
  output logic [STATE_W-1:0]           st_data,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*STATE_W-1:0]   req_state,
  output logic [NUM_REQ-1:0]           grant,
  output logic [STATE_W-1:0]           cur_state,
  output logic [1:0]                   phase,
  output logic [15:0]                  round_cnt
);

  localparam int MAXLAT = (BL_CYC > FL_CYC) ? BL_CYC : FL_CYC;
  localparam int CW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);
  localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] BL_LOAD = CW'((BL_CYC > 0) ? BL_CYC - 1 : 0);
  localparam logic [CW-1:0] FL_LOAD = CW'((FL_CYC > 0) ? FL_CYC - 1 : 0);

  typedef enum logic [1:0] {
    SEND  = 2'd0,
    BWAIT = 2'd1,
    RECV  = 2'd2,
    FWAIT = 2'd3
  } phaseT;

  phaseT                phaseQ;
  logic [STATE_W-1:0]   stateQ;
  logic [PW-1:0]        rrPtr;
  logic [15:0]          roundCnt;
  logic [CW-1:0]        waitCnt;

  logic                 found;
  int                   winIdx;
  logic [NUM_REQ-1:0]   winOneHot;
  logic [STATE_W-1:0]   winState;
  logic [PW-1:0]        nextPtr;

  // Round-robin pick: scan offsets from rrPtr upward, first set request wins.
  always_comb begin
    found     = 1'b0;
    winIdx    = 0;
    winOneHot = '0;
    winState  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(rrPtr) + k) % NUM_REQ) == i)) begin
          found        = 1'b1;
          winIdx       = i;
          winOneHot[i] = 1'b1;
          winState     = req_state[i*STATE_W +: STATE_W];
        end
      end
    end
    nextPtr = PW'((winIdx + 1) % NUM_REQ);
  end

  // Handshake: st_valid is high for the whole SEND phase and the state transfers on any
  // rising edge where st_valid && st_ready; grant is the one-cycle acknowledge in RECV.
  assign st_valid  = (phaseQ == SEND);
  assign grant     = (phaseQ == RECV) ? winOneHot : '0;
  assign st_data   = stateQ;
  assign cur_state = stateQ;
  assign phase     = phaseQ;
  assign round_cnt = roundCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phaseQ   <= SEND;
      stateQ   <= RESET_STATE;
      rrPtr    <= '0;
      roundCnt <= '0;
      waitCnt  <= '0;
    end else begin
      case (phaseQ)
        SEND: begin
          if (st_ready) begin
            if (BL_CYC == 0) begin
              phaseQ <= RECV;
            end else begin
              phaseQ  <= BWAIT;
              waitCnt <= BL_LOAD;
            end
          end
        end
        BWAIT: begin
          if (waitCnt == '0) phaseQ <= RECV;
          else               waitCnt <= waitCnt - CW'(1);
        end
        RECV: begin
          if (found) begin
            stateQ   <= winState;
            rrPtr    <= nextPtr;
            roundCnt <= roundCnt + 16'd1;
            if (FL_CYC == 0) begin
              phaseQ <= SEND;
            end else begin
              phaseQ  <= FWAIT;
              waitCnt <= FL_LOAD;
            end
          end
        end
        FWAIT: begin
          if (waitCnt == '0) phaseQ <= SEND;
          else               waitCnt <= waitCnt - CW'(1);
        end
        default: phaseQ <= SEND;
      endcase
    end
  end

endmodule

// File: doc/state_seq_arbiter.md
Name: state_seq_arbiter

Overview:
- Clocked controller that owns the FSM state register and sequences its update loop.
- Each round has four steps: publish the current state on an output handshake, wait a backward latency, arbitrate one next-state proposal from NUM_REQ requesters (round-robin), then wait a forward latency.
- Sits between the FSM next-state logic blocks (requesters) and the consumers of the current state.

Parameters:
NUM_REQ, 4, number of next-state requesters (>=1)
STATE_W, 3, state width in bits
BL_CYC, 8, cycles spent in BWAIT after a state send (>=0)
FL_CYC, 2, cycles spent in FWAIT after a state update (>=0)
RESET_STATE, 0, state register value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  out  1  current state offered to consumer
st_ready  in  1  consumer accepts st_data
st_data  out  STATE_W  current state value
req  in  NUM_REQ  per-requester next-state request, held until granted
req_state  in  NUM_REQ*STATE_W  proposed next state; requester i uses bits [i*STATE_W +: STATE_W]
grant  out  NUM_REQ  one-hot acknowledge; combinational in RECV
cur_state  out  STATE_W  state register, always visible
phase  out  2  SEND=0, BWAIT=1, RECV=2, FWAIT=3
round_cnt  out  16  completed updates, wraps 0xFFFF->0

Behaviour:
- Reset: rst_n low forces outputs immediately, without waiting for a clock edge:
  - phase=SEND, state=RESET_STATE, st_valid=1, grant=0.
  - RR pointer=0, round_cnt=0, wait counter=0.
  - Applies from any phase, including mid-wait or mid-grant. Leaving reset begins a fresh round in SEND.
- SEND:
  - st_valid=1, st_data=state.
  - Transfer occurs on an edge with st_valid&&st_ready.
  - On transfer: go to BWAIT with counter=BL_CYC-1, or go straight to RECV if BL_CYC=0.
  - st_valid=0 in every other phase.
- BWAIT:
  - Counter decrements each cycle. When it reaches 0, the next edge enters RECV.
  - Total BWAIT duration is exactly BL_CYC cycles.
  - req is ignored and grant=0.
- RECV:
  - If req==0: stay in RECV, grant=0.
  - Otherwise: grant=one-hot of the first set req bit, searching upward from the RR pointer modulo NUM_REQ.
  - On that edge:
    - state <= req_state slice of the winner.
    - pointer <= (winner+1) mod NUM_REQ.
    - round_cnt <= round_cnt+1.
    - Go to FWAIT with counter=FL_CYC-1, or straight to SEND if FL_CYC=0.
  - Exactly one grant per round. Requesters must drop or replace req the cycle after their grant.
  - Losing requests stay pending and are not acknowledged.
- FWAIT:
  - Same rules as BWAIT, using FL_CYC, then SEND.
  - The new state is visible on cur_state from the first FWAIT cycle.
- Minimum round: 1 (SEND) + BL_CYC + 1 (RECV) + FL_CYC cycles. Defaults give 12 cycles.
- Simultaneous events:
  - req is asserted during SEND/BWAIT/FWAIT: no grant; the request waits for RECV.
  - st_ready asserted outside SEND: ignored.
- Width rules:
  - Wait counter width = $clog2(max(BL_CYC,FL_CYC)+1), minimum 1.
  - req_state slices are taken verbatim; no state validity checking.
- Outputs are registered except grant and st_valid, which are decoded from phase and req.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, st_ready=0 -> phase=SEND, st_valid=1, st_data=0, round_cnt=0 held indefinitely; grant=0.
- Single round, defaults: st_ready=1 at cycle 0, req=4'b0010, slice1=3'd5 -> BWAIT cycles 1-8; RECV at cycle 9 with grant=4'b0010; cur_state=5 at cycle 10; FWAIT cycles 10-11; SEND cycle 12 with st_data=5; round_cnt=1.
- Round-robin: req=4'b1111 held continuously, st_ready=1 -> grants over four rounds are 0001, 0010, 0100, 1000, then 0001; cur_state follows each slice value (1, 2, 3, 4).
- Early request and backpressure: req=4'b0100 asserted during BWAIT, st_ready held 0 for 5 SEND cycles -> no grant before RECV; st_data stable while stalled; grant=0100 on the first RECV cycle.
- Zero latency: BL_CYC=0, FL_CYC=0, st_ready=1, req=4'b0001 -> phase sequence SEND, RECV, SEND; one update every 2 cycles.
- Reset mid-operation: assert rst_n during FWAIT with cur_state=6 and round_cnt=3 -> all outputs immediately show reset values (state 0, round_cnt 0); RR pointer restarts so requester 0 wins the next round when req=4'b1111.
